// File: rtl/pipelined_datapath.sv
// Register file + ALU execute/writeback engine with registered N/Z/C/V flags.
// Optional macro DATAPATH_BYPASS_EN forwards the pending writeback to the read ports.
module pipelined_datapath #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_en,
  input  logic [3:0]                   alu_opcode,
  input  logic [DATA_W-1:0]            imm_value,
  input  logic                         write_en,
  input  logic [$clog2(REG_COUNT)-1:0] write_addr,
  input  logic [$clog2(REG_COUNT)-1:0] ra_addr,
  input  logic [$clog2(REG_COUNT)-1:0] rb_addr,
  output logic [DATA_W-1:0]            read_a,
  output logic [DATA_W-1:0]            read_b,
  output logic [DATA_W-1:0]            alu_result,
  output logic                         alu_zero,
  output logic                         alu_carry,
  output logic                         alu_neg,
  output logic                         alu_ovf,
  output logic                         wb_pending
);
  localparam int ADDR_W = $clog2(REG_COUNT);
  localparam int MSB    = DATA_W - 1;

  logic [DATA_W-1:0] r_mem [REG_COUNT];
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_z, r_c, r_n, r_v;

  logic [DATA_W-1:0] w_a, w_b, w_res;
  logic [DATA_W:0]   w_wide;
  logic              w_c, w_v, w_op_ok, w_ci;

  always_comb begin
    w_a = (ra_addr == '0) ? '0 : r_mem[ra_addr];
    w_b = (rb_addr == '0) ? '0 : r_mem[rb_addr];
`ifdef DATAPATH_BYPASS_EN
    // r_wb_addr is never 0 while valid, so r0 stays hardwired
    if (r_wb_valid && ra_addr == r_wb_addr) w_a = r_wb_data;
    if (r_wb_valid && rb_addr == r_wb_addr) w_b = r_wb_data;
`endif
  end

  // Carry-in only participates for ADC/SBB (opcode bit 3 set)
  assign w_ci = alu_opcode[3] & r_c;

  always_comb begin
    w_res   = '0;
    w_wide  = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_op_ok = 1'b1;
    case (alu_opcode)
      4'd0, 4'd8: begin
        w_wide = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_ci};
        w_res  = w_wide[MSB:0];
        w_c    = w_wide[DATA_W];
        w_v    = (w_a[MSB] == w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      4'd1, 4'd9: begin
        w_wide = {1'b0, w_a} - {1'b0, w_b} - {{DATA_W{1'b0}}, w_ci};
        w_res  = w_wide[MSB:0];
        w_c    = w_wide[DATA_W];
        w_v    = (w_a[MSB] != w_b[MSB]) && (w_res[MSB] != w_a[MSB]);
      end
      4'd2:  w_res = w_a & w_b;
      4'd3:  w_res = w_a | w_b;
      4'd4:  w_res = w_a ^ w_b;
      4'd5:  w_res = ~w_a;
      4'd6:  begin w_res = {w_a[MSB-1:0], 1'b0};     w_c = w_a[MSB]; end
      4'd7:  begin w_res = {1'b0, w_a[MSB:1]};       w_c = w_a[0];   end
      4'd10: begin w_res = {w_a[MSB-1:0], w_a[MSB]}; w_c = w_a[MSB]; end
      4'd11: begin w_res = {w_a[0], w_a[MSB:1]};     w_c = w_a[0];   end
      4'd12: w_res = w_b;
      default: w_op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_mem[i] <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_z        <= 1'b0;
      r_c        <= 1'b0;
      r_n        <= 1'b0;
      r_v        <= 1'b0;
    end else begin
      if (r_wb_valid) r_mem[r_wb_addr] <= r_wb_data;
      r_wb_valid <= write_en && (write_addr != '0) && w_op_ok;
      if (write_en && (write_addr != '0) && w_op_ok) begin
        r_wb_addr <= write_addr;
        r_wb_data <= alu_en ? w_res : imm_value;
      end
      if (alu_en && w_op_ok) begin
        r_z <= (w_res == '0);
        r_n <= w_res[MSB];
        r_c <= w_c;
        r_v <= w_v;
      end
    end
  end

  assign read_a     = w_a;
  assign read_b     = w_b;
  assign alu_result = w_res;
  assign alu_zero   = r_z;
  assign alu_carry  = r_c;
  assign alu_neg    = r_n;
  assign alu_ovf    = r_v;
  assign wb_pending = r_wb_valid;
endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench: directed plan plus random ops against a write-visibility model.
// Honours DATAPATH_BYPASS_EN to pick the result visibility delay.
module tb_pipelined_datapath;
  localparam int DW = 8;
  localparam int RC = 16;
  localparam int M  = 1 << DW;
  localparam int H  = M / 2;
`ifdef DATAPATH_BYPASS_EN
  localparam int WB_LAG = 0;
`else
  localparam int WB_LAG = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_en;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] imm_value;
  logic          write_en;
  logic [3:0]    write_addr, ra_addr, rb_addr;
  logic [DW-1:0] read_a, read_b, alu_result;
  logic          alu_zero, alu_carry, alu_neg, alu_ovf, wb_pending;

  pipelined_datapath #(.DATA_W(DW), .REG_COUNT(RC)) dut (
    .clk(clk), .rst(rst), .alu_en(alu_en), .alu_opcode(alu_opcode),
    .imm_value(imm_value), .write_en(write_en), .write_addr(write_addr),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .read_a(read_a), .read_b(read_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_neg(alu_neg), .alu_ovf(alu_ovf), .wb_pending(wb_pending)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; int ready; } wr_t;
  wr_t q[$];
  int  m_mem [RC];
  int  m_z, m_c, m_n, m_v, m_pend;
  int  cnt;
  int  p_res, p_c, p_v;
  bit  p_ok;
  int  ncmp = 0, nfail = 0;

  function automatic void ref_alu(input int op, input int a, input int b, input int ci,
                                  output int res, output int c, output int v, output bit ok);
    int sa, sb, t, st, cc;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    cc = (op >= 8) ? ci : 0;
    res = 0; c = 0; v = 0; ok = 1'b1;
    case (op)
      0, 8: begin
        t = a + b + cc; res = t % M; c = (t >= M) ? 1 : 0;
        st = sa + sb + cc; v = (st >= H || st < -H) ? 1 : 0;
      end
      1, 9: begin
        t = a - b - cc; res = (t + M) % M; c = (t < 0) ? 1 : 0;
        st = sa - sb - cc; v = (st >= H || st < -H) ? 1 : 0;
      end
      2:  res = a & b;
      3:  res = a | b;
      4:  res = a ^ b;
      5:  res = M - 1 - a;
      6:  begin res = (a * 2) % M; c = a / H; end
      7:  begin res = a / 2; c = a % 2; end
      10: begin res = (a * 2) % M + a / H; c = a / H; end
      11: begin res = a / 2 + (a % 2) * H; c = a % 2; end
      12: res = b;
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setin(input bit r, input bit ae, input int op, input int imm,
                       input bit we, input int wa, input int ra, input int rb);
    rst = r; alu_en = ae; alu_opcode = op[3:0]; imm_value = imm[DW-1:0];
    write_en = we; write_addr = wa[3:0]; ra_addr = ra[3:0]; rb_addr = rb[3:0];
  endtask

  task automatic settle();
    int a, b;
    #2;
    a = m_mem[ra_addr];
    b = m_mem[rb_addr];
    ref_alu(int'(alu_opcode), a, b, m_c, p_res, p_c, p_v, p_ok);
    chk("read_a", read_a, a);
    chk("read_b", read_b, b);
    chk("alu_result", alu_result, p_res);
  endtask

  task automatic edge_chk();
    @(posedge clk);
    cnt++;
    if (!rst) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      q.delete();
      m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_pend = 0;
    end else begin
      if (alu_en && p_ok) begin
        m_z = (p_res == 0); m_n = p_res / H; m_c = p_c; m_v = p_v;
      end
      m_pend = (write_en && write_addr != 0 && p_ok) ? 1 : 0;
      if (m_pend != 0)
        q.push_back('{int'(write_addr), alu_en ? p_res : int'(imm_value), cnt + WB_LAG});
      while (q.size() > 0 && q[0].ready <= cnt) begin
        m_mem[q[0].addr] = q[0].data;
        void'(q.pop_front());
      end
    end
    #1;
    chk("flag_z", alu_zero, m_z);
    chk("flag_c", alu_carry, m_c);
    chk("flag_n", alu_neg, m_n);
    chk("flag_v", alu_ovf, m_v);
    chk("wb_pending", wb_pending, m_pend);
  endtask

  task automatic step(input bit r, input bit ae, input int op, input int imm,
                      input bit we, input int wa, input int ra, input int rb);
    setin(r, ae, op, imm, we, wa, ra, rb);
    settle();
    edge_chk();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cnt = 0; p_ok = 1'b0; p_res = 0; p_c = 0; p_v = 0;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    edge_chk();
    edge_chk();
    step(1, 0, 0, 0, 0, 0, 0, 5);
    chk("rst_r0", read_a, 0);

    // Fill r[i] = i*0x11 from the immediate path
    for (int i = 0; i < RC; i++) step(1, 0, 0, i * 17, 1, i, 0, 0);
    idle(2);
    for (int i = 0; i < RC; i++) begin
      setin(1, 0, 0, 0, 0, 0, i, RC - 1 - i);
      settle();
      chk("fill_a", read_a, i * 17);
      chk("fill_b", read_b, (RC - 1 - i) * 17);
      edge_chk();
    end

    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < RC; i++) begin
      setin(1, 0, 0, 0, 0, 0, i, i);
      settle();
      chk("rst_clear", read_a, 0);
      edge_chk();
    end

    // Accumulating ADD chain on r1
    step(1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 2, 0, 0);
    idle(2);
    for (int k = 0; k < 64; k++) begin
      setin(1, 1, 0, 0, 1, 1, 1, 2);
      settle();
`ifdef DATAPATH_BYPASS_EN
      chk("chain_a", read_a, k);
`endif
      edge_chk();
    end
    idle(2);
    setin(1, 0, 0, 0, 0, 0, 1, 2);
    settle();
`ifdef DATAPATH_BYPASS_EN
    chk("chain_final", read_a, 'h40);
`endif
    edge_chk();

    // Repeated SUB walks r12 through the borrow point
    step(1, 0, 0, 'h7F, 1, 12, 0, 0);
    step(1, 0, 0, 'h0A, 1, 6, 0, 0);
    idle(2);
    setin(1, 1, 1, 0, 1, 12, 12, 6);
    settle();
    chk("sub_first", alu_result, 'h75);
    edge_chk();
    for (int k = 1; k < 25; k++) step(1, 1, 1, 0, 1, 12, 12, 6);
    idle(2);

    step(1, 0, 0, 'hFF, 1, 3, 0, 0);
    step(1, 0, 0, 'h01, 1, 4, 0, 0);
    step(1, 0, 0, 'h7F, 1, 5, 0, 0);
    step(1, 0, 0, 'h00, 1, 7, 0, 0);
    idle(2);
    setin(1, 1, 0, 0, 0, 0, 3, 4);
    settle(); chk("add_ff_res", alu_result, 0);
    edge_chk(); chk("add_ff_z", alu_zero, 1); chk("add_ff_c", alu_carry, 1);
    setin(1, 1, 8, 0, 0, 0, 7, 7);
    settle(); chk("adc_res", alu_result, 1);
    edge_chk(); chk("adc_c", alu_carry, 0);
    setin(1, 1, 0, 0, 0, 0, 5, 4);
    settle(); chk("add_ovf_res", alu_result, 'h80);
    edge_chk(); chk("add_ovf_n", alu_neg, 1); chk("add_ovf_v", alu_ovf, 1);
    setin(1, 1, 11, 0, 0, 0, 4, 0);
    settle(); chk("ror_res", alu_result, 'h80);
    edge_chk(); chk("ror_c", alu_carry, 1);
    setin(1, 0, 0, 0, 0, 0, 3, 0);
    settle(); chk("we0_keep", read_a, 'hFF);
    edge_chk();

    // r0 write and reserved opcode
    setin(1, 0, 0, 'hAA, 1, 0, 0, 0);
    settle();
    edge_chk(); chk("r0_pend", wb_pending, 0);
    setin(1, 1, 14, 0, 1, 5, 3, 4);
    settle(); chk("op14_res", alu_result, 0);
    edge_chk(); chk("op14_c", alu_carry, 1); chk("op14_pend", wb_pending, 0);
    idle(2);
    setin(1, 0, 0, 0, 0, 0, 0, 5);
    settle(); chk("r0_read", read_a, 0); chk("op14_r5", read_b, 'h7F);
    edge_chk();

    // Reset right behind a pending write
    setin(1, 0, 0, 'h33, 1, 5, 0, 0);
    settle();
    edge_chk(); chk("mid_pend", wb_pending, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_pend_rst", wb_pending, 0);
    idle(2);
    setin(1, 0, 0, 0, 0, 0, 5, 5);
    settle(); chk("mid_r5", read_a, 0);
    edge_chk();

    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 59) != 0), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, M - 1), $urandom_range(0, 3) != 0, $urandom_range(0, RC - 1),
           $urandom_range(0, RC - 1), $urandom_range(0, RC - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised next-generation register-file plus ALU datapath.
- Register file is DATA_W bits wide and REG_COUNT deep; register 0 is hardwired to zero.
- Issue stage (read and ALU) is followed by a registered writeback stage, with bypass from the pending writeback to the read ports.
- Adds registered N/Z/C/V flags and carry-chained ops (ADC/SBB, rotates). Sits under the control unit as the core execute/writeback engine.

Parameters:
- DATA_W, 8, operand/register width (>=4).
- REG_COUNT, 16, number of registers (power of two, >=2); ADDR_W = $clog2(REG_COUNT) is a derived localparam.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- alu_en  in  1  1: writeback source is ALU result; 0: source is imm_value. Also gates flag update.
- alu_opcode  in  4  ALU operation (encoding in Behaviour).
- imm_value  in  DATA_W  immediate write data.
- write_en  in  1  issue a write to write_addr this cycle.
- write_addr  in  ADDR_W  destination register.
- ra_addr  in  ADDR_W  read port A address.
- rb_addr  in  ADDR_W  read port B address.
- read_a  out  DATA_W  combinational read A, bypassed.
- read_b  out  DATA_W  combinational read B, bypassed.
- alu_result  out  DATA_W  combinational ALU output for the current operands.
- alu_zero, alu_carry, alu_neg, alu_ovf  out  1 each  registered flags.
- wb_pending  out  1  a writeback is held in the WB register.

Behaviour:
- Reset: rst=0 at a posedge clears all registers, wb_valid, wb_addr, wb_data and all four flags to 0. Reset mid-operation discards any pending writeback. rst has priority over every other input.
- Reads are combinational. Address 0 always returns 0.
  - If wb_valid and addr==wb_addr, the port returns wb_data (bypass).
  - Otherwise the port returns the array contents.
- ALU operands are A=read_a and B=read_b, i.e. post-bypass values.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~A
  - 6 SHL: A<<1
  - 7 SHR: A>>1, logical
  - 8 ADC: A+B+C
  - 9 SBB: A-B-C
  - 10 ROL: {A[W-2:0],A[W-1]}
  - 11 ROR: {A[0],A[W-1:1]}
  - 12 PASSB: B
  - 13-15: result 0, flags unchanged, no write.
- Carry:
  - ADD/ADC: carry-out of the DATA_W+1-bit sum.
  - SUB/SBB: borrow, i.e. 1 when the unsigned minuend is less than the subtrahend (plus C for SBB).
  - Shift/rotate: the bit shifted out.
  - Logic ops and PASSB: C=0.
- Overflow: signed overflow for ADD/ADC/SUB/SBB; 0 for all other ops.
- Z = (result==0); N = result[W-1].
- Flags update at a posedge only when alu_en=1 and the opcode is valid, independent of write_en.
- Writeback pipeline (latency 1 cycle to the bypass, 2 cycles to the array):
  - At posedge with write_en=1, write_addr!=0 and the op valid: wb_valid<=1, wb_addr<=write_addr, wb_data<=(alu_en ? alu_result : imm_value).
  - Otherwise wb_valid<=0.
  - At the same posedge, if wb_valid was 1, array[wb_addr]<=wb_data.
- Back-to-back writes to the same register: the newer value lands in WB while the older one commits. The result is correct and in order.
- Writes to register 0 never set wb_valid.
- wb_pending = wb_valid.

Optional Feature:
- Macro DATAPATH_BYPASS_EN.
- Defined: bypass as described.
- Undefined: read ports return the array contents only. A result becomes readable 2 posedges after issue. An ADD r1=r1+r2 issued every cycle then uses stale r1 on alternate cycles. The hazard is documented, and the bench checks it under a separate define.

Test Plan:
- Reset then fill: write r[i]=i*0x11 for i=0..15 with alu_en=0. Two cycles later, read ra=i, rb=15-i: r0 reads 00, r15 reads FF, r1 reads 11. Pulse rst=0 for one posedge: every read returns 00 and all flags are 0.
- Bypass chain: r1=0, r2=1, then ADD r1=r1+r2 with write_en=1 for 64 consecutive cycles → r1=0x40, Z=0, C=0. Each cycle read_a increments by exactly 1.
- Subtract/borrow: r12=0x7F, r6=0x0A, then SUB r12=r12-r6 repeated 25 times. First result is 0x75. Borrow C=1 first appears when the minuend drops below 0x0A (at 0x07-0x0A → 0xFD); V=0 throughout.
- Flag ops:
  - ADD 0xFF+0x01 → result 0x00, Z=1, C=1.
  - Then ADC 0x00+0x00 → result 0x01, C=0.
  - ADD 0x7F+0x01 → 0x80, N=1, V=1.
  - ROR 0x01 → 0x80, C=1.
- Register 0 and write gating:
  - Write r0=0xAA → r0 still reads 00 and wb_pending stays 0.
  - write_en=0 with alu_en=1 ADD → no register change, but flags update.
  - Opcode 14 → no change of any state.
- Reset mid-pipeline: issue a write of r5=0x33 and assert rst=0 on the very next posedge. r5 reads 00 and wb_pending=0 after reset deasserts.
